// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared seven-segment definitions used by the display driver and by the
// seg_display_capture read-back monitor.
//   SEG_A..SEG_G : bit index of each segment within a 7-bit pattern
//   GLYPH_0..F   : active-high abcdefg patterns for the 16 hex glyphs
//   GLYPH_TABLE  : the glyphs indexed by the nibble they represent
//   NUM_DIGITS   : digits on the multiplexed display
//   is_onehot4   : helper used to qualify the anode select
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SA = 7'(1 << SEG_A);
  localparam logic [6:0] SB = 7'(1 << SEG_B);
  localparam logic [6:0] SC = 7'(1 << SEG_C);
  localparam logic [6:0] SD = 7'(1 << SEG_D);
  localparam logic [6:0] SE = 7'(1 << SEG_E);
  localparam logic [6:0] SF = 7'(1 << SEG_F);
  localparam logic [6:0] SG = 7'(1 << SEG_G);

  localparam logic [6:0] GLYPH_0 = SA | SB | SC | SD | SE | SF;
  localparam logic [6:0] GLYPH_1 = SB | SC;
  localparam logic [6:0] GLYPH_2 = SA | SB | SD | SE | SG;
  localparam logic [6:0] GLYPH_3 = SA | SB | SC | SD | SG;
  localparam logic [6:0] GLYPH_4 = SB | SC | SF | SG;
  localparam logic [6:0] GLYPH_5 = SA | SC | SD | SF | SG;
  localparam logic [6:0] GLYPH_6 = SA | SC | SD | SE | SF | SG;
  localparam logic [6:0] GLYPH_7 = SA | SB | SC;
  localparam logic [6:0] GLYPH_8 = SA | SB | SC | SD | SE | SF | SG;
  localparam logic [6:0] GLYPH_9 = SA | SB | SC | SD | SF | SG;
  localparam logic [6:0] GLYPH_A = SA | SB | SC | SE | SF | SG;
  localparam logic [6:0] GLYPH_B = SC | SD | SE | SF | SG;
  localparam logic [6:0] GLYPH_C = SA | SD | SE | SF;
  localparam logic [6:0] GLYPH_D = SB | SC | SD | SE | SG;
  localparam logic [6:0] GLYPH_E = SA | SD | SE | SF | SG;
  localparam logic [6:0] GLYPH_F = SA | SE | SF | SG;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  // True when exactly one bit is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// ---------------------------------------------------------------------------
// seg_glyph_decode
// Purely combinational: active-high abcdefg pattern -> hex nibble.
//   pattern : 7-bit active-high segment pattern (bit0 = a)
//   nibble  : decoded value, 0 when the pattern is not a hex glyph
//   err     : 1 when the pattern matches none of the 16 glyphs
// ---------------------------------------------------------------------------
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  logic [15:0] match;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (pattern == GLYPH_TABLE[gi]);
    end
  endgenerate

  // Glyphs are all distinct, so at most one match bit is set and OR-ing
  // the matching indices yields the nibble directly.
  always_comb begin
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) nibble = nibble | 4'(i);
    end
  end

  assign err = ~|match;

endmodule

// File: rtl/seg_display_capture.sv
// ---------------------------------------------------------------------------
// seg_display_capture
// Reads back a time-multiplexed 4-digit common-anode seven-segment bus and
// recovers the displayed hex value as a frame on a valid/ready output.
//   clk, rst_n  : clock, asynchronous active-low reset
//   an_n[3:0]   : digit enables, active low, digit 0 least significant
//   seg_n[6:0]  : segments, active low, bit0 = a ... bit6 = g
//   out_value   : captured frame, nibble i = digit i
//   out_err     : bit i set when digit i was not a legal hex glyph
//   out_valid / out_ready : frame handshake
//   overrun     : one-cycle pulse when a completed frame is dropped
// Optional feature (macro SEG_CAPTURE_DP_EN):
//   dp_n        : decimal point, active low, part of the stability check
//   out_dp[3:0] : captured decimal point per digit (1 = lit)
// Parameter STABLE_CYCLES (1..255): identical samples needed to capture.
// ---------------------------------------------------------------------------
module seg_display_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
`ifdef SEG_CAPTURE_DP_EN
  input  logic        dp_n,
  output logic [3:0]  out_dp,
`endif
  output logic [15:0] out_value,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

`ifdef SEG_CAPTURE_DP_EN
  localparam int SAMPLE_W = 12;
  logic [SAMPLE_W-1:0] sample;
  assign sample = {dp_n, an_n, seg_n};
`else
  localparam int SAMPLE_W = 11;
  logic [SAMPLE_W-1:0] sample;
  assign sample = {an_n, seg_n};
`endif

  logic [SAMPLE_W-1:0]   prev_reg;
  logic [7:0]            run_reg;
  logic [7:0]            run_next;
  logic                  capture;
  logic [NUM_DIGITS-1:0] sel;
  logic                  eligible;
  logic                  sample_differs;
  logic [3:0]            dec_nibble;
  logic                  dec_err;

  logic [NUM_DIGITS-1:0] mask_reg;
  logic [NUM_DIGITS-1:0] mask_next;
  logic                  frame_complete;

  logic [3:0]            frame_nib_reg [NUM_DIGITS];
  logic                  frame_err_reg [NUM_DIGITS];
  logic [15:0]           frame_value;
  logic [3:0]            frame_err;

  logic [15:0]           out_value_reg;
  logic [3:0]            out_err_reg;
  logic                  out_valid_reg;
  logic                  overrun_reg;

  assign sel            = ~an_n;
  assign eligible       = is_onehot4(sel);
  assign sample_differs = (sample != prev_reg);

  // Run counter and capture strobe. A capture fires only on the edge where
  // the run first reaches RUN_MAX; a saturated run that stays equal never
  // re-fires, while a fresh run may capture immediately when RUN_MAX is 1.
  always_comb begin
    run_next = 8'd0;
    capture  = 1'b0;
    if (eligible) begin
      if (sample_differs)
        run_next = 8'd1;
      else if (run_reg != RUN_MAX)
        run_next = run_reg + 8'd1;
      else
        run_next = run_reg;
      capture = (run_next == RUN_MAX) && (sample_differs || (run_reg != RUN_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= '1;
      run_reg  <= 8'd0;
    end else begin
      prev_reg <= sample;
      run_reg  <= run_next;
    end
  end

  seg_glyph_decode u_decode (
    .pattern (~seg_n),
    .nibble  (dec_nibble),
    .err     (dec_err)
  );

  // Completion is seen one cycle after the last capture; in that cycle the
  // mask clears while still accepting a capture belonging to the next frame.
  assign frame_complete = (mask_reg == '1);

  always_comb begin
    mask_next = frame_complete ? '0 : mask_reg;
    if (capture) mask_next = mask_next | sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_reg <= '0;
    else        mask_reg <= mask_next;
  end

  // Working frame, one slot per digit; a re-capture simply overwrites.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          frame_nib_reg[gi] <= 4'd0;
          frame_err_reg[gi] <= 1'b0;
        end else if (capture && sel[gi]) begin
          frame_nib_reg[gi] <= dec_nibble;
          frame_err_reg[gi] <= dec_err;
        end
      end
      assign frame_value[gi*4 +: 4] = frame_nib_reg[gi];
      assign frame_err[gi]          = frame_err_reg[gi];
    end
  endgenerate

`ifdef SEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] frame_dp_reg;
  logic [NUM_DIGITS-1:0] out_dp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_dp_reg <= '0;
    else if (capture) frame_dp_reg <= (frame_dp_reg & ~sel) | (sel & {NUM_DIGITS{~dp_n}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_dp_reg <= '0;
    else if (frame_complete && (!out_valid_reg || out_ready)) out_dp_reg <= frame_dp_reg;
  end

  assign out_dp = out_dp_reg;
`endif

  // Single-entry output buffer. It may reload in the same cycle it is
  // being emptied, so back-to-back frames never see a spurious overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_value_reg <= 16'd0;
      out_err_reg   <= 4'd0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (frame_complete) begin
        if (!out_valid_reg || out_ready) begin
          out_value_reg <= frame_value;
          out_err_reg   <= frame_err;
          out_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_value = out_value_reg;
  assign out_err   = out_err_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_seg_display_capture.sv
module tb_seg_display_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  seg_display_capture #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .out_value (out_value),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int n_checks       = 0;
  int n_fail         = 0;
  int n_frames       = 0;
  int overrun_cycles = 0;
  int exp_overrun    = 0;

  // Hand-written active-high abcdefg glyphs (bit0 = a).
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show_raw(input int digit, input logic [6:0] pattern, input int cycles);
    an_n  = ~(4'b0001 << digit);
    seg_n = ~pattern;
    step(cycles);
  endtask

  task automatic push(input logic [15:0] value, input logic [3:0] err);
    frame_t f;
    f.value = value;
    f.err   = err;
    exp_q.push_back(f);
  endtask

  task automatic scan_frame(input logic [15:0] value, input int cycles, input bit do_push);
    if (do_push) push(value, 4'h0);
    for (int d = 0; d < 4; d++) show_raw(d, glyph(value[d*4 +: 4]), cycles);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks held frames stay
  // put while back-pressured, and counts overrun cycles.
  initial begin : monitor
    frame_t      e;
    logic        hold_pending = 1'b0;
    logic [15:0] hold_value   = 16'h0;
    logic [3:0]  hold_err     = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_value", {12'h0, out_err, out_value}, {12'h0, hold_err, hold_value});
        end
        if (overrun) overrun_cycles++;
        if (out_valid && out_ready) begin
          n_frames++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got value=%h err=%h, required no frame", out_value, out_err);
          end else begin
            e = exp_q.pop_front();
            check("frame_value", 32'(out_value), 32'(e.value));
            check("frame_err", 32'(out_err), 32'(e.err));
            $display("frame %0d value=%h err=%h (expected %h/%h)", n_frames, out_value, out_err, e.value, e.err);
          end
        end
        hold_pending = out_valid && !out_ready;
        hold_value   = out_value;
        hold_err     = out_err;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    an_n      = 4'hF;
    seg_n     = 7'h7F;
    out_ready = 1'b1;
    #2;
    check("reset_value", 32'(out_value), 32'd0);
    check("reset_err", 32'(out_err), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Steady scan 0x1234, 8 cycles per digit, with output latency check.
    push(16'h1234, 4'h0);
    show_raw(0, glyph(4'h4), 8);
    show_raw(1, glyph(4'h3), 8);
    show_raw(2, glyph(4'h2), 8);
    show_raw(3, glyph(4'h1), 4);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    step(1);
    check("latency_valid", 32'(out_valid), 32'd1);
    step(3);

    // Every glyph on digit 0, then blank and a non-glyph.
    for (int g = 0; g < 16; g++) scan_frame(16'(g), 5, 1'b1);
    push(16'h0000, 4'b0001);
    show_raw(0, 7'h00, 5);
    for (int d = 1; d < 4; d++) show_raw(d, glyph(4'h0), 5);
    push(16'h0000, 4'b0001);
    show_raw(0, 7'h0B, 5);
    for (int d = 1; d < 4; d++) show_raw(d, glyph(4'h0), 5);

    // Glitch: digit 2 interrupted after 3 cycles must restart its run.
    push(16'h9765, 4'h0);
    show_raw(0, glyph(4'h5), 6);
    show_raw(1, glyph(4'h6), 6);
    show_raw(3, glyph(4'h9), 6);
    show_raw(2, glyph(4'h7), 3);
    an_n = 4'hF;
    step(1);
    show_raw(2, glyph(4'h7), 4);
    check("glitch_no_early", 32'(out_valid), 32'd0);
    step(1);
    check("glitch_valid", 32'(out_valid), 32'd1);
    step(2);

    // Back-pressure: second frame dropped with a single overrun pulse.
    out_ready = 1'b0;
    scan_frame(16'hABCD, 6, 1'b1);
    scan_frame(16'h1111, 6, 1'b0);
    exp_overrun++;
    step(2);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step(1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Completion coinciding with a handshake.
    scan_frame(16'h2468, 6, 1'b1);
    push(16'h1357, 4'h0);
    show_raw(0, glyph(4'h7), 6);
    show_raw(1, glyph(4'h5), 6);
    show_raw(2, glyph(4'h3), 6);
    show_raw(3, glyph(4'h1), 4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("coinc_valid", 32'(out_valid), 32'd1);
    check("coinc_value", 32'(out_value), 32'h1357);
    check("coinc_overrun", 32'(overrun), 32'd0);
    step(3);

    // Reset mid-frame while a frame is held: everything clears at once.
    show_raw(0, glyph(4'hA), 8);
    show_raw(1, glyph(4'hB), 8);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_value", 32'(out_value), 32'd0);
    check("arst_err", 32'(out_err), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    scan_frame(16'hF00D, 6, 1'b1);
    step(4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("overrun_cycles", 32'(overrun_cycles), 32'(exp_overrun));
    check("frame_count", 32'(n_frames), 32'd23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
